pc_sequencer: RTL and testbench

PC_SEQUENCER -- requirements
Module: pc_sequencer

---
 rtl/pc_sequencer.sv | 85 ++++++++
 tb/tb_pc_sequencer.sv | 187 ++++++++++++++++++
 2 files changed

// File: rtl/pc_sequencer.sv
// Program counter sequencer: IDLE/RUN/STALL/HALT FSM with jump/branch redirect.
// Optional retired-instruction counter enabled by defining RETIRE_COUNT_EN.
module pc_sequencer #(
  parameter int PC_WIDTH = 5,
  parameter logic [PC_WIDTH-1:0] RESET_PC = '0
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                start,
  input  logic                stall,
  input  logic                jump,
  input  logic [PC_WIDTH-1:0] jump_target,
  input  logic                branch,
  input  logic [PC_WIDTH-1:0] branch_off,
  input  logic                halt,
  output logic [PC_WIDTH-1:0] pc,
  output logic                pc_valid,
  output logic [1:0]          state
`ifdef RETIRE_COUNT_EN
  , output logic [7:0]        retired
`endif
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    STALL = 2'd2,
    HALT  = 2'd3
  } state_t;

  state_t              state_q, state_n;
  logic [PC_WIDTH-1:0] pc_n;
  logic                pc_upd;

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q  <= IDLE;
      pc       <= RESET_PC;
      pc_valid <= 1'b0;
    end else begin
      state_q  <= state_n;
      pc       <= pc_n;
      pc_valid <= (state_n == RUN);
    end
  end

  assign state = state_q;

  // Fixed priority in RUN: halt > stall > jump > branch > sequential.
  always_comb begin
    state_n = state_q;
    pc_n    = pc;
    pc_upd  = 1'b0;
    case (state_q)
      IDLE: begin
        pc_n = RESET_PC;
        if (start) state_n = RUN;
      end
      RUN: begin
        if (halt)        state_n = HALT;
        else if (stall)  state_n = STALL;
        else begin
          pc_upd = 1'b1;
          if (jump)        pc_n = jump_target;
          else if (branch) pc_n = pc + PC_WIDTH'(1) + branch_off;
          else             pc_n = pc + PC_WIDTH'(1);
        end
      end
      STALL: begin
        if (halt)        state_n = HALT;
        else if (!stall) state_n = RUN;
      end
      HALT: state_n = HALT;
      default: state_n = IDLE;
    endcase
  end

`ifdef RETIRE_COUNT_EN
  always_ff @(posedge clock) begin
    if (reset)                         retired <= 8'd0;
    else if (pc_upd && retired != 8'hff) retired <= retired + 8'd1;
  end
`endif

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed self-checking bench for pc_sequencer (default parameters).
// Covers RETIRE_COUNT_EN behaviour when that macro is defined.
module tb_pc_sequencer;

  localparam int W = 5;

  logic         clock = 1'b0;
  logic         reset, start, stall, jump, branch, halt;
  logic [W-1:0] jump_target, branch_off, pc;
  logic         pc_valid;
  logic [1:0]   state;
`ifdef RETIRE_COUNT_EN
  logic [7:0]   retired;
`endif

  int checks = 0;
  int errors = 0;

  pc_sequencer dut (
    .clock(clock), .reset(reset), .start(start), .stall(stall),
    .jump(jump), .jump_target(jump_target), .branch(branch),
    .branch_off(branch_off), .halt(halt), .pc(pc), .pc_valid(pc_valid),
    .state(state)
`ifdef RETIRE_COUNT_EN
    , .retired(retired)
`endif
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic chk3(input string tag, input int s, input int p, input int v);
    chk({tag, ".state"}, 32'(state), 32'(s));
    chk({tag, ".pc"}, 32'(pc), 32'(p));
    chk({tag, ".valid"}, 32'(pc_valid), 32'(v));
  endtask

  // Redirect to an absolute pc from RUN in one cycle.
  task automatic goto(input int target);
    jump = 1'b1; jump_target = W'(target);
    tick();
    jump = 1'b0;
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; stall = 1'b0; jump = 1'b0; branch = 1'b0;
    halt = 1'b0; jump_target = '0; branch_off = '0;
    tick(); tick();
    chk3("reset", 0, 0, 0);

    // IDLE ignores everything but start
    reset = 1'b0; jump = 1'b1; jump_target = 5'd17; stall = 1'b1; halt = 1'b1;
    tick();
    chk3("idle_hold", 0, 0, 0);
    jump = 1'b0; stall = 1'b0; halt = 1'b0;

    start = 1'b1;
    tick();
    chk3("start", 1, 0, 1);
    start = 1'b0;

    // sequential run with wrap 31 -> 0
    for (int i = 1; i <= 33; i++) begin
      tick();
      chk($sformatf("seq%0d.pc", i), 32'(pc), 32'(i % 32));
      chk($sformatf("seq%0d.valid", i), 32'(pc_valid), 32'd1);
    end

    // pc=1 -> advance to 4, then jump+branch together
    tick(); tick(); tick();
    chk("to4.pc", 32'(pc), 32'd4);
    jump = 1'b1; jump_target = 5'd20; branch = 1'b1; branch_off = 5'd3;
    tick();
    chk3("jump_wins", 1, 20, 1);
    jump = 1'b0; branch = 1'b0;
    tick();
    chk("branch_dropped.pc", 32'(pc), 32'd21);

    // negative branch and wrapping branch
    goto(2);
    chk("goto2.pc", 32'(pc), 32'd2);
    branch = 1'b1; branch_off = 5'b11101;
    tick();
    chk("br_neg.pc", 32'(pc), 32'd0);
    branch = 1'b0;
    goto(30);
    branch = 1'b1; branch_off = 5'd4;
    tick();
    chk("br_wrap.pc", 32'(pc), 32'd3);
    branch = 1'b0;

    // stall for 3 cycles with jump asserted throughout
    goto(7);
    stall = 1'b1; jump = 1'b1; jump_target = 5'd15;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk3($sformatf("stall%0d", i), 2, 7, 0);
    end
    stall = 1'b0; jump = 1'b0;
    tick();
    chk3("resume", 1, 7, 1);
    tick();
    chk3("after_stall", 1, 8, 1);

    // halt holds pc against start/jump
    goto(9);
    halt = 1'b1;
    tick();
    chk3("halt", 3, 9, 0);
    halt = 1'b0; start = 1'b1; jump = 1'b1; jump_target = 5'd3;
    tick(); tick();
    chk3("halt_hold", 3, 9, 0);
    start = 1'b0; jump = 1'b0;
    reset = 1'b1;
    tick();
    chk3("halt_reset", 0, 0, 0);

    // halt from STALL
    reset = 1'b0; start = 1'b1;
    tick(); tick();
    chk3("run2", 1, 1, 1);
    stall = 1'b1;
    tick();
    chk3("stall2", 2, 1, 0);
    halt = 1'b1;
    tick();
    chk3("stall_halt", 3, 1, 0);
    halt = 1'b0; stall = 1'b0;

    // start held through reset -> RUN one cycle after release
    reset = 1'b1;
    tick();
    chk3("rst_start", 0, 0, 0);
    reset = 1'b0;
    tick();
    chk3("rel_start", 1, 0, 1);
    start = 1'b0;
    tick();
    stall = 1'b1;
    tick();
    chk3("stall3", 2, 1, 0);
    reset = 1'b1;
    tick();
    chk3("stall_reset", 0, 0, 0);
    reset = 1'b0; stall = 1'b0;

`ifdef RETIRE_COUNT_EN
    chk("ret.rst", 32'(retired), 32'd0);
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("ret.start", 32'(retired), 32'd0);
    tick(); tick(); tick();
    chk("ret.three", 32'(retired), 32'd3);
    stall = 1'b1;
    tick();
    chk("ret.stall", 32'(retired), 32'd3);
    stall = 1'b0;
    tick();
    chk("ret.resume", 32'(retired), 32'd3);
    for (int i = 0; i < 300; i++) tick();
    chk("ret.sat", 32'(retired), 32'd255);
    tick();
    chk("ret.hold", 32'(retired), 32'd255);
    reset = 1'b1;
    tick();
    chk("ret.reset", 32'(retired), 32'd0);
    reset = 1'b0;
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
